// File: rtl/divui_seq_pkg.sv
// Shared definitions for the sequential unsigned divider: FSM encoding and
// counter sizing.
package divui_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/divui_seq_if.sv
// Elastic operand/result channels of the sequential divider: two joined
// operand inputs and one quotient output.
interface divui_seq_if #(
    parameter int unsigned DATA_TYPE = 32
) ();

    logic [DATA_TYPE-1:0] lhs;
    logic                 lhs_valid;
    logic                 lhs_ready;
    logic [DATA_TYPE-1:0] rhs;
    logic                 rhs_valid;
    logic                 rhs_ready;
    logic [DATA_TYPE-1:0] outs;
    logic                 outs_valid;
    logic                 outs_ready;

    modport master (
        output lhs, lhs_valid, rhs, rhs_valid, outs_ready,
        input  lhs_ready, rhs_ready, outs, outs_valid
    );

    modport slave (
        input  lhs, lhs_valid, rhs, rhs_valid, outs_ready,
        output lhs_ready, rhs_ready, outs, outs_valid
    );

endinterface

// File: rtl/divui_seq_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// remainder and subtract the divisor when it fits.
module divui_seq_step #(
    parameter int unsigned DATA_TYPE = 32
) (
    input  logic [DATA_TYPE-1:0] rem_i,
    input  logic                 q_msb_i,
    input  logic [DATA_TYPE-1:0] div_i,
    output logic [DATA_TYPE-1:0] rem_o,
    output logic                 q_bit_o
);

    logic [DATA_TYPE:0] shifted;

    // The remainder is always below the divisor, so the difference fits in
    // DATA_TYPE bits; a zero divisor always "fits" and yields all-ones.
    always_comb begin
        shifted = {rem_i, q_msb_i};
        q_bit_o = (shifted >= {1'b0, div_i});
        rem_o   = q_bit_o ? DATA_TYPE'(shifted - {1'b0, div_i}) : shifted[DATA_TYPE-1:0];
    end

endmodule

// File: rtl/divui_seq.sv
// Iterative unsigned divider: joins dividend and divisor, produces one
// quotient bit per cycle, and presents the quotient on an elastic output.
module divui_seq
    import divui_seq_pkg::*;
#(
    parameter int unsigned DATA_TYPE = 32
) (
    input logic         clk,
    input logic         rst,
    divui_seq_if.slave  bus
);

    localparam int unsigned           CntW    = cnt_width(DATA_TYPE);
    localparam logic [CntW-1:0]       CntLast = CntW'(DATA_TYPE - 1);

    state_e               state_q;
    logic                 outs_valid_q;
    logic [DATA_TYPE-1:0] q_q;
    logic [DATA_TYPE-1:0] rem_q;
    logic [DATA_TYPE-1:0] div_q;
    logic [CntW-1:0]      cnt_q;
    logic [DATA_TYPE-1:0] rem_d;
    logic                 q_bit_d;
    logic                 can_accept;
    logic                 accept;

    assign can_accept = (state_q == StIdle) || ((state_q == StDone) && bus.outs_ready);
    assign accept     = can_accept && bus.lhs_valid && bus.rhs_valid;

    assign bus.lhs_ready  = can_accept && bus.rhs_valid;
    assign bus.rhs_ready  = can_accept && bus.lhs_valid;
    assign bus.outs       = q_q;
    assign bus.outs_valid = outs_valid_q;

    divui_seq_step #(
        .DATA_TYPE(DATA_TYPE)
    ) u_step (
        .rem_i   (rem_q),
        .q_msb_i (q_q[DATA_TYPE-1]),
        .div_i   (div_q),
        .rem_o   (rem_d),
        .q_bit_o (q_bit_d)
    );

    // The dividend shifts out of q_q's MSB while quotient bits shift into its LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            outs_valid_q <= 1'b0;
            q_q          <= '0;
            rem_q        <= '0;
            div_q        <= '0;
            cnt_q        <= '0;
        end else if (accept) begin
            state_q      <= StBusy;
            outs_valid_q <= 1'b0;
            q_q          <= bus.lhs;
            div_q        <= bus.rhs;
            rem_q        <= '0;
            cnt_q        <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StBusy: begin
                    rem_q <= rem_d;
                    q_q   <= {q_q[DATA_TYPE-2:0], q_bit_d};
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        state_q      <= StDone;
                        outs_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (bus.outs_ready) begin
                        state_q      <= StIdle;
                        outs_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divui_seq.sv
// Directed and randomised checks of divui_seq at 8-bit and 32-bit widths.
module tb_divui_seq;

    localparam int unsigned NRand    = 1000;
    localparam int unsigned RandTout = 70000;

    logic clk;
    logic rst;

    int tests = 0;
    int fails = 0;

    divui_seq_if #(.DATA_TYPE(8))  b8 ();
    divui_seq_if #(.DATA_TYPE(32)) b32 ();

    divui_seq #(.DATA_TYPE(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    divui_seq #(.DATA_TYPE(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] l;
        logic [7:0] r;
        logic [7:0] e;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Caller is just past the accept edge with valids dropped and outs_ready=1.
    task automatic wait_result(input logic [7:0] e, input string nm);
        @(negedge clk);
        check({nm, " valid@0"}, 64'(b8.outs_valid), 64'd0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s valid@%0d", nm, k), 64'(b8.outs_valid), 64'(k == 8));
            if (k < 8) begin
                check($sformatf("%s busy ready@%0d", nm, k), 64'(b8.lhs_ready), 64'd0);
            end
        end
        check({nm, " outs"}, 64'(b8.outs), 64'(e));
        @(posedge clk);
        @(negedge clk);
        check({nm, " valid after consume"}, 64'(b8.outs_valid), 64'd0);
    endtask

    task automatic run8(input logic [7:0] l, input logic [7:0] r, input logic [7:0] e,
                        input string nm);
        @(posedge clk);
        #1;
        b8.lhs = l;
        b8.rhs = r;
        b8.lhs_valid = 1'b1;
        b8.rhs_valid = 1'b1;
        b8.outs_ready = 1'b1;
        @(negedge clk);
        check({nm, " lhs_ready"}, 64'(b8.lhs_ready), 64'd1);
        check({nm, " rhs_ready"}, 64'(b8.rhs_ready), 64'd1);
        @(posedge clk);
        #1;
        b8.lhs_valid = 1'b0;
        b8.rhs_valid = 1'b0;
        wait_result(e, nm);
    endtask

    logic [31:0] exp_q [$];

    initial begin
        vecs[0] = '{8'd100, 8'd7,   8'd14};
        vecs[1] = '{8'h5A,  8'd0,   8'hFF};
        vecs[2] = '{8'd200, 8'd10,  8'd20};
        vecs[3] = '{8'd255, 8'd16,  8'd15};
        vecs[4] = '{8'd0,   8'd5,   8'd0};
        vecs[5] = '{8'd3,   8'd9,   8'd0};
        vecs[6] = '{8'd255, 8'd1,   8'd255};
        vecs[7] = '{8'd255, 8'd255, 8'd1};
        vecs[8] = '{8'd128, 8'd3,   8'd42};
        vecs[9] = '{8'd250, 8'd17,  8'd14};

        rst = 1'b1;
        b8.lhs = '0;  b8.rhs = '0;  b8.lhs_valid = 1'b0;  b8.rhs_valid = 1'b0;
        b8.outs_ready = 1'b0;
        b32.lhs = '0; b32.rhs = '0; b32.lhs_valid = 1'b0; b32.rhs_valid = 1'b0;
        b32.outs_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset outs_valid8", 64'(b8.outs_valid), 64'd0);
        check("reset outs8", 64'(b8.outs), 64'd0);
        check("reset outs_valid32", 64'(b32.outs_valid), 64'd0);
        check("reset outs32", 64'(b32.outs), 64'd0);

        for (int i = 0; i < 10; i++) begin
            run8(vecs[i].l, vecs[i].r, vecs[i].e, $sformatf("vec%0d", i));
        end

        // Skewed join: dividend waits three cycles for its divisor.
        @(posedge clk);
        #1;
        b8.lhs = 8'd200;
        b8.rhs = 8'd10;
        b8.lhs_valid = 1'b1;
        b8.rhs_valid = 1'b0;
        b8.outs_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("skew lhs_ready@%0d", c), 64'(b8.lhs_ready), 64'd0);
            check($sformatf("skew rhs_ready@%0d", c), 64'(b8.rhs_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        b8.rhs_valid = 1'b1;
        @(negedge clk);
        check("skew lhs_ready@3", 64'(b8.lhs_ready), 64'd1);
        check("skew rhs_ready@3", 64'(b8.rhs_ready), 64'd1);
        @(posedge clk);
        #1;
        b8.lhs_valid = 1'b0;
        b8.rhs_valid = 1'b0;
        wait_result(8'd20, "skew");

        // Backpressure with the next pair already waiting.
        @(posedge clk);
        #1;
        b8.lhs = 8'd100;
        b8.rhs = 8'd7;
        b8.lhs_valid = 1'b1;
        b8.rhs_valid = 1'b1;
        b8.outs_ready = 1'b0;
        @(posedge clk);
        #1;
        b8.lhs = 8'd255;
        b8.rhs = 8'd16;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp ready@%0d", k), 64'(b8.lhs_ready | b8.rhs_ready), 64'd0);
        end
        check("bp valid", 64'(b8.outs_valid), 64'd1);
        check("bp outs", 64'(b8.outs), 64'd14);
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp hold valid%0d", j), 64'(b8.outs_valid), 64'd1);
            check($sformatf("bp hold outs%0d", j), 64'(b8.outs), 64'd14);
            check($sformatf("bp hold ready%0d", j), 64'(b8.lhs_ready | b8.rhs_ready), 64'd0);
        end
        b8.outs_ready = 1'b1;
        #1;
        check("bp release lhs_ready", 64'(b8.lhs_ready), 64'd1);
        check("bp release rhs_ready", 64'(b8.rhs_ready), 64'd1);
        @(posedge clk);
        #1;
        b8.lhs_valid = 1'b0;
        b8.rhs_valid = 1'b0;
        wait_result(8'd15, "bp next");

        // Reset in the middle of a division abandons it.
        @(posedge clk);
        #1;
        b8.lhs = 8'd200;
        b8.rhs = 8'd10;
        b8.lhs_valid = 1'b1;
        b8.rhs_valid = 1'b1;
        @(posedge clk);
        #1;
        b8.lhs_valid = 1'b0;
        b8.rhs_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst busy valid", 64'(b8.outs_valid), 64'd0);
        check("rst busy outs", 64'(b8.outs), 64'd0);
        b8.lhs_valid = 1'b1;
        #1;
        check("rst busy idle rhs_ready", 64'(b8.rhs_ready), 64'd1);
        b8.lhs_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("rst no stale result", 64'(b8.outs_valid), 64'd0);
        run8(8'd255, 8'd16, 8'd15, "after rst");

        // 32-bit regression with random stalls on both sides.
        begin
            int          sent;
            int          recv;
            int          cyc;
            logic [31:0] cur_l;
            logic [31:0] cur_r;
            logic [31:0] exp_v;
            logic [31:0] held;
            bit          hold;
            bit          in_x;
            bit          out_x;
            sent = 0;
            recv = 0;
            cyc  = 0;
            hold = 1'b0;
            held = '0;
            @(posedge clk);
            #1;
            while (recv < int'(NRand) && cyc < int'(RandTout)) begin
                if (!b32.lhs_valid && !b32.rhs_valid && sent < int'(NRand)) begin
                    unique case (sent % 8)
                        0: begin
                            cur_r = 32'd0;
                            cur_l = $urandom;
                        end
                        1: begin
                            cur_r = $urandom;
                            if (cur_r == 0) cur_r = 32'd1;
                            cur_l = $urandom % cur_r;
                        end
                        2: begin
                            cur_r = $urandom_range(1, 15);
                            cur_l = $urandom;
                        end
                        default: begin
                            cur_r = $urandom >> $urandom_range(0, 31);
                            cur_l = $urandom;
                        end
                    endcase
                    b32.lhs = cur_l;
                    b32.rhs = cur_r;
                end
                if (sent < int'(NRand)) begin
                    if (!b32.lhs_valid && $urandom_range(0, 3) != 0) b32.lhs_valid = 1'b1;
                    if (!b32.rhs_valid && $urandom_range(0, 3) != 0) b32.rhs_valid = 1'b1;
                end
                b32.outs_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (hold) begin
                    check("rand hold valid", 64'(b32.outs_valid), 64'd1);
                    check("rand hold outs", 64'(b32.outs), 64'(held));
                end
                in_x  = b32.lhs_valid && b32.lhs_ready;
                out_x = b32.outs_valid && b32.outs_ready;
                hold  = b32.outs_valid && !b32.outs_ready;
                held  = b32.outs;
                if (out_x) begin
                    if (exp_q.size() == 0) begin
                        check("rand unexpected result", 64'(b32.outs), 64'hDEAD_0000_0000_0000);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check($sformatf("rand result %0d", recv), 64'(b32.outs), 64'(exp_v));
                    end
                    recv++;
                end
                @(posedge clk);
                #1;
                if (in_x) begin
                    exp_q.push_back((b32.rhs == 0) ? 32'hFFFF_FFFF : b32.lhs / b32.rhs);
                    sent++;
                    b32.lhs_valid = 1'b0;
                    b32.rhs_valid = 1'b0;
                end
                cyc++;
            end
            check("rand results received", 64'(recv), 64'(NRand));
            check("rand operands sent", 64'(sent), 64'(NRand));
            check("rand leftover expected", 64'(exp_q.size()), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/divui_seq.md
Name: divui_seq

Overview:
- Iterative unsigned integer divider for the elastic dataflow arith library.
- Joins two operand channels (lhs dividend, rhs divisor) and computes the quotient with radix-2 restoring division, one quotient bit per cycle.
- Presents the quotient on one elastic output channel at full DATA_TYPE width.
- Typically feeds a truncation or compare stage directly downstream.
- Used where a fully pipelined divider costs too much area; throughput is one division per DATA_TYPE+1 cycles at best.

Parameters:
- DATA_TYPE, 32, bit width of lhs, rhs and outs; legal range 2..64.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- lhs  input  DATA_TYPE  dividend.
- lhs_valid  input  1  dividend valid.
- lhs_ready  output  1  dividend accepted.
- rhs  input  DATA_TYPE  divisor.
- rhs_valid  input  1  divisor valid.
- rhs_ready  output  1  divisor accepted.
- outs  output  DATA_TYPE  quotient floor(lhs/rhs).
- outs_valid  output  1  quotient valid.
- outs_ready  input  1  downstream accepts quotient.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- States: IDLE, BUSY, DONE.
- Reset: state=IDLE, outs_valid=0, outs=0, iteration counter=0, remainder/divisor registers=0.
- rst has priority over all other events. Asserting rst in BUSY or DONE abandons the operation; no output transfer occurs.
- can_accept = (state==IDLE) | (state==DONE & outs_ready).
- Join rule (combinational):
  - lhs_ready = can_accept & rhs_valid.
  - rhs_ready = can_accept & lhs_valid.
  - An operand transfer happens only when lhs_valid & rhs_valid & can_accept; neither operand is consumed alone.
- Accept edge:
  - Latch dividend into the quotient/shift register and divisor into the divisor register.
  - Clear the remainder; counter=0; state=BUSY.
- BUSY, per cycle (one restoring step):
  - r' = {r[DATA_TYPE-1:0], q[MSB]}, with the remainder DATA_TYPE+1 bits wide.
  - If r' >= {0,divisor}: r = r' - divisor and shift 1 into q LSB; else r = r' and shift 0.
  - counter increments.
  - When counter reaches DATA_TYPE-1 on this edge, state=DONE.
- Latency: outs_valid rises exactly DATA_TYPE cycles after the accept edge. With DATA_TYPE=8, accept at edge 0 gives outs_valid=1 after edge 8.
- DONE:
  - outs = q, held stable while outs_valid=1 and outs_ready=0.
  - On outs_valid & outs_ready, with no new operand pair: state=IDLE, outs_valid=0.
  - Same-cycle consume and accept: state=BUSY, outs_valid=0 next cycle. Back-to-back period is DATA_TYPE+1 cycles.
- Divide by zero: no special path. The restoring algorithm yields q = all ones (2^DATA_TYPE-1) with the same latency.
- lhs_ready and rhs_ready stay 0 throughout BUSY, whatever valids arrive.
- outs_valid never depends combinationally on input valids. ready outputs depend combinationally on valids and outs_ready only.

Decomposition:
- Shared arith package/header holds:
  - the state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - a constant function for the counter width: clog2(DATA_TYPE).
- One natural sub-module: divui_seq_step. It is a combinational restoring step with inputs remainder, q MSB and divisor, and outputs next remainder and quotient bit. It is reusable by a future remui_seq.
- The FSM, counter and registers stay in divui_seq.

Test Plan:
- DATA_TYPE=8, lhs=100, rhs=7, both valid in the same cycle, outs_ready=1:
  - lhs_ready=rhs_ready=1 for that cycle only;
  - outs=14 and outs_valid=1 exactly 8 cycles later, for one cycle.
- DATA_TYPE=8, lhs=0x5A, rhs=0 -> outs=0xFF after 8 cycles.
- Skewed join: lhs_valid at cycle 0, rhs_valid at cycle 3 (lhs=200, rhs=10):
  - lhs_ready=0 during cycles 0-2;
  - both readys=1 at cycle 3;
  - outs=20 at cycle 11.
- Backpressure: outs_ready=0 for 5 cycles after outs_valid with a new operand pair pending:
  - outs held stable; readys=0;
  - on outs_ready=1, result transfers and the new pair is accepted the same cycle;
  - the next result arrives 8 cycles later.
- Reset mid-BUSY (cycle 4 of 8):
  - next cycle outs_valid=0, state IDLE;
  - a fresh 255/16 then yields 15 with full latency.
- DATA_TYPE=32 random regression: 1000 operand pairs with random valid/ready stalls, including rhs=0 and lhs<rhs -> every outs matches floor(lhs/rhs) (or 0xFFFFFFFF for rhs=0), in order, with no drops or duplicates.
